spi_target: RTL
===============

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI frame word (4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on SCLK/MOSI/CS_n (2..3).
REQ-003 SHALL have parameter IDLE_FILL, default all-ones, word shifted on MISO when no TX data is available.
REQ-004 CLK  in  1  sole clock (108 MHz nominal); reset is asynchronous and active-high.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SCLK  in  1  SPI clock from initiator, asynchronous to CLK, mode 0 (CPOL=0, CPHA=0).
REQ-007 CS_n  in  1  chip select from initiator, active low, asynchronous.
REQ-008 MOSI  in  1  serial data in, MSB first.
REQ-009 MISO  out  1  serial data out, MSB first.
REQ-010 MISO_OE  out  1  high while selected; pad drives MISO only when high.
REQ-011 RX_DATA  out  DATA_WIDTH  last complete received word.
REQ-012 RX_VALID  out  1  one-CLK pulse when RX_DATA updates.
REQ-013 TX_DATA  in  DATA_WIDTH  next word to transmit.
REQ-014 TX_LOAD  in  1  one-CLK strobe writing TX_DATA; ignored when TX_READY low.
REQ-015 TX_READY  out  1  high when TX storage can accept a word.
REQ-016 SEL_START  out  1  one-CLK pulse on synchronized CS_n falling edge.
REQ-017 SEL_END  out  1  one-CLK pulse on synchronized CS_n rising edge.
REQ-018 UNDERRUN  out  1  sticky; set when IDLE_FILL is substituted; cleared on SEL_START.

Function
REQ-019 SHALL synchronize SCLK, CS_n, MOSI through SYNC_STAGES flops; edge detection SHALL use synchronized values only.
REQ-020 SHALL support SCLK up to CLK/6; faster SCLK is out of scope.
REQ-021 States IDLE -> LOAD -> SHIFT -> IDLE; IDLE->LOAD on synchronized CS_n fall; LOAD->SHIFT next CLK; any state->IDLE on synchronized CS_n high.
REQ-022 In LOAD, SHALL move the next TX word (or IDLE_FILL if none, setting UNDERRUN) into the TX shift register and drive its MSB on MISO before the first SCLK rise.
REQ-023 On each synchronized SCLK rise in SHIFT, SHALL shift the sampled MOSI into the RX shift register LSB and increment the bit counter (mod DATA_WIDTH).
REQ-024 On the DATA_WIDTH-th rise, SHALL copy the RX shift register to RX_DATA and pulse RX_VALID the next CLK (pin-to-RX_VALID latency SYNC_STAGES+2 CLK).
REQ-025 On each synchronized SCLK fall in SHIFT, SHALL present the next TX bit; after a word boundary, the fall SHALL load the next TX word (or IDLE_FILL, setting UNDERRUN).
REQ-026 No RX backpressure; RX_DATA SHALL be overwritten by each new word.
REQ-027 CS_n rise mid-word: partial RX bits discarded, no RX_VALID, bit counter cleared, any loaded-but-unsent TX word discarded.
REQ-028 TX_LOAD in the same CLK as a shift-register load with storage empty: TX_DATA SHALL bypass directly into the shift register, no UNDERRUN.
REQ-029 MISO_OE SHALL equal the inverted synchronized CS_n; MISO SHALL be 0 when MISO_OE is low.

Reset
REQ-030 While RESET high: state IDLE, shift registers and counter 0, RX_DATA 0, RX_VALID/SEL_START/SEL_END/UNDERRUN/MISO/MISO_OE 0, TX storage empty, TX_READY 1, synchronizers preset to CS_n=1, SCLK=0, MOSI=0.
REQ-031 Reset asserted mid-transfer SHALL abort it; after release, the block SHALL wait for a fresh CS_n fall before shifting.

Configuration
REQ-032 Macro SPI_TARGET_TXFIFO_EN defined: TX storage is a 4-deep FIFO; TX_READY low only when 4 words are held.
REQ-033 Macro SPI_TARGET_TXFIFO_EN undefined: TX storage is a single holding register; TX_READY low while it is occupied.

Structure
REQ-034 Package spi_target_pkg SHALL hold the state enum, SYNC_STAGES limits and FIFO depth constant (4).
REQ-035 The TX FIFO SHALL be sub-module spi_target_txfifo, instantiated only under SPI_TARGET_TXFIFO_EN.

Verification
REQ-036 Reset, CS_n low, SCLK=18 MHz, MOSI 0xA5 -> RX_DATA=0xA5, a single RX_VALID pulse; MISO=0xFF; UNDERRUN=1.
REQ-037 TX_LOAD 0x3C before CS_n fall, 2 words clocked -> MISO bytes 0x3C, 0xFF; UNDERRUN set at word 2; SEL_START/SEL_END one pulse each.
REQ-038 FIFO build: load 0x11,0x22,0x33,0x44 -> TX_READY low after the 4th; 5th load ignored; MISO 0x11..0x44 in order.
REQ-039 CS_n rise after 5 bits -> no RX_VALID; next transfer of 0x5A -> RX_DATA=0x5A (counter cleared).
REQ-040 RESET pulse after bit 3 -> all outputs at reset values; the transfer after release yields correct RX_DATA and the MISO MSB first.

Source files
------------

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared types and constants for the SPI target block.
//   state_t              - controller states (IDLE, LOAD, SHIFT)
//   SYNC_MIN / SYNC_MAX  - legal range of the SYNC_STAGES parameter
//   TXFIFO_DEPTH         - depth of the optional TX FIFO
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 3;
    localparam int TXFIFO_DEPTH = 4;

endpackage

// File: rtl/spi_target_txfifo.sv
// spi_target_txfifo: small TX word FIFO, depth TXFIFO_DEPTH (power of two).
// Ports:
//   CLK, RESET  - clock, asynchronous active-high reset
//   push        - write push_data (caller guarantees not full)
//   push_data   - word to write
//   pop         - drop head word (caller guarantees not empty)
//   head        - oldest stored word
//   empty, full - occupancy flags
module spi_target_txfifo
    import spi_target_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = $clog2(TXFIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [TXFIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(TXFIFO_DEPTH));

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target, MSB first, all SPI pins oversampled by CLK.
// Ports:
//   CLK, RESET          - system clock, asynchronous active-high reset
//   SCLK, CS_n, MOSI    - SPI pins from the initiator (asynchronous)
//   MISO, MISO_OE       - serial out and pad enable (enable = selected)
//   RX_DATA, RX_VALID   - last received word, one-CLK update strobe
//   TX_DATA, TX_LOAD    - next word to send, one-CLK write strobe
//   TX_READY            - TX storage can take a word
//   SEL_START, SEL_END  - one-CLK pulses on select / deselect
//   UNDERRUN            - sticky: IDLE_FILL was sent; cleared on SEL_START
// Build option: define SPI_TARGET_TXFIFO_EN for a 4-deep TX FIFO instead of
// a single holding register.
// SCLK must be at most CLK/6; SYNC_STAGES must lie in SYNC_MIN..SYNC_MAX.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SCLK,
    input  logic                  CS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_LOAD,
    output logic                  TX_READY,
    output logic                  SEL_START,
    output logic                  SEL_END,
    output logic                  UNDERRUN
);
    localparam int CW = $clog2(DATA_WIDTH);

    // ---------------- synchronizers and edge detect ----------------
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    // ---------------- controller state ----------------
    state_t                state;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic [CW-1:0]         bit_cnt;
    logic                  rx_done;    // word completed, publish next CLK
    logic                  tx_reload;  // word boundary passed, next fall loads
    logic                  last_bit;

    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

    // ---------------- TX storage ----------------
    logic                  st_valid, tx_push, tx_pop, load_req;
    logic [DATA_WIDTH-1:0] st_data, next_word;

    // A load happens entering SHIFT and on the first fall after a word ends.
    assign load_req = ~cs_s & ((state == ST_LOAD) |
                               ((state == ST_SHIFT) & sclk_fall & tx_reload));

    // With storage empty, a same-cycle TX_LOAD goes straight into the shift
    // register and is not stored.
    assign next_word = st_valid ? st_data : (TX_LOAD ? TX_DATA : IDLE_FILL);
    assign tx_pop    = load_req & st_valid;
    assign tx_push   = TX_LOAD & TX_READY & ~(load_req & ~st_valid);

`ifdef SPI_TARGET_TXFIFO_EN
    logic fifo_empty, fifo_full;

    spi_target_txfifo #(.DATA_WIDTH(DATA_WIDTH)) u_txfifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (tx_push),
        .push_data (TX_DATA),
        .pop       (tx_pop),
        .head      (st_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign st_valid = ~fifo_empty;
    assign TX_READY = ~fifo_full;
`else
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_data;

    // push requires an empty register and pop a full one, so never both.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (tx_push) begin
            hold_vld  <= 1'b1;
            hold_data <= TX_DATA;
        end else if (tx_pop) begin
            hold_vld  <= 1'b0;
        end
    end

    assign st_valid = hold_vld;
    assign st_data  = hold_data;
    assign TX_READY = ~hold_vld;
`endif

    // ---------------- FSM and datapath ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            rx_done   <= 1'b0;
            tx_reload <= 1'b0;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
            SEL_START <= 1'b0;
            SEL_END   <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            SEL_START <= cs_fall;
            SEL_END   <= cs_rise;
            RX_VALID  <= rx_done;
            rx_done   <= 1'b0;
            if (rx_done)
                RX_DATA <= rx_sr;

            if (cs_fall)
                UNDERRUN <= 1'b0;
            else if (load_req & ~st_valid & ~TX_LOAD)
                UNDERRUN <= 1'b1;

            if (cs_s) begin
                // Deselect: drop partial RX bits and any unsent TX word.
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                rx_sr     <= '0;
                tx_sr     <= '0;
                tx_reload <= 1'b0;
            end else begin
                if (load_req) begin
                    tx_sr     <= next_word;
                    tx_reload <= 1'b0;
                end
                unique case (state)
                    ST_IDLE:  if (cs_fall) state <= ST_LOAD;
                    ST_LOAD:  state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (sclk_rise) begin
                            rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
                            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                            rx_done <= last_bit;
                            if (last_bit)
                                tx_reload <= 1'b1;
                        end else if (sclk_fall & ~tx_reload) begin
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    assign MISO_OE = ~cs_s;
    assign MISO    = MISO_OE & tx_sr[DATA_WIDTH-1];

endmodule
